// File: rtl/alu_src_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// alu_src_ctrl_fsm
//   Multicycle control sequencer for a MIPS-style datapath. Steps
//   FETCH -> DECODE -> EXEC -> WB per instruction and drives the ALU operand
//   selects (ALUSrcA/ALUSrcB), the ALU operation code and all datapath enables.
//   Memory states (FETCH, MRD, MWR) wait on mem_ready with a bounded timeout.
//
//   Build option: define ILLEGAL_OP_TRAP_EN to trap unknown opcodes and unknown
//   R-type funct codes to the ILL state (exception vector). When undefined,
//   unknown opcodes complete as a NOP in DECODE and unknown funct codes
//   execute as add.
//
// Ports
//   clk, reset_n            clock (rising edge), async active-low reset
//   opcode, funct           IR[31:26], IR[5:0]; held stable by the IR
//   mem_ready               memory completes the current read/write
//   ALUSrcA                 0=PC, 1=rs
//   ALUSrcB                 00=rt, 01=4, 10=SE imm, 11=SE imm<<2
//   ALUOp                   001 add, 010 sub, 011 and, 110 xor, 000 idle
//   PCWrite..MemToReg       datapath enables
//   PCSource                00 ALU, 01 ALUOut, 10 jump target, 11 exc vector
//   instr_done              pulse on the last cycle of an instruction
//   bus_err                 pulse on memory timeout
//   state_dbg               current state encoding
//
// Handshake: mem_ready is only sampled in FETCH, MRD and MWR; a transfer
// completes in the cycle mem_ready is high, and the request strobe
// (MemRead/MemWrite) is held until then or until the wait counter expires.
// ---------------------------------------------------------------------------
module alu_src_ctrl_fsm #(
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       mem_ready,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [2:0] ALUOp,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemToReg,
    output logic [1:0] PCSource,
    output logic       instr_done,
    output logic       bus_err,
    output logic [3:0] state_dbg
);

    typedef enum logic [3:0] {
        S_RST    = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MADDR  = 4'd3,
        S_MRD    = 4'd4,
        S_MWB    = 4'd5,
        S_MWR    = 4'd6,
        S_R_EX   = 4'd7,
        S_R_WB   = 4'd8,
        S_I_EX   = 4'd9,
        S_I_WB   = 4'd10,
        S_BR     = 4'd11,
        S_JMP    = 4'd12,
        S_ILL    = 4'd13
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic [3:0] r_wait_cnt;
    logic       w_wait_max;
    logic       w_timeout;
    logic       w_mem_wait;

    assign state_dbg  = r_state;
    assign w_wait_max = (r_wait_cnt == 4'(WAIT_MAX));
    assign w_mem_wait = ((r_state == S_FETCH) || (r_state == S_MRD) ||
                         (r_state == S_MWR)) && !mem_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_RST;
            r_wait_cnt <= 4'd0;
        end else begin
            r_state <= w_state_next;
            // A timeout re-enters FETCH from FETCH, so clear on timeout too,
            // not only on a change of state.
            if (w_timeout || (w_state_next != r_state))
                r_wait_cnt <= 4'd0;
            else if (w_mem_wait)
                r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

    always_comb begin
        w_state_next = S_FETCH;
        w_timeout    = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ALUOp        = 3'b000;
        PCWrite      = 1'b0;
        PCWriteCond  = 1'b0;
        IorD         = 1'b0;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRWrite      = 1'b0;
        RegWrite     = 1'b0;
        RegDst       = 1'b0;
        MemToReg     = 1'b0;
        PCSource     = 2'b00;
        instr_done   = 1'b0;
        bus_err      = 1'b0;

        case (r_state)
            S_FETCH: begin
                // Ready on the final count still completes the fetch.
                if (!mem_ready && w_wait_max) begin
                    w_timeout    = 1'b1;
                    bus_err      = 1'b1;
                    w_state_next = S_FETCH;
                end else begin
                    MemRead      = 1'b1;
                    ALUSrcB      = 2'b01;
                    ALUOp        = 3'b001;
                    IRWrite      = mem_ready;
                    PCWrite      = mem_ready;
                    w_state_next = mem_ready ? S_DECODE : S_FETCH;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                ALUOp   = 3'b001;
                case (opcode)
                    6'h00:        w_state_next = S_R_EX;
                    6'h23, 6'h2B: w_state_next = S_MADDR;
                    6'h08:        w_state_next = S_I_EX;
                    6'h04:        w_state_next = S_BR;
                    6'h02:        w_state_next = S_JMP;
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        w_state_next = S_ILL;
`else
                        w_state_next = S_FETCH;
                        instr_done   = 1'b1;
`endif
                    end
                endcase
            end
            S_MADDR: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ALUOp        = 3'b001;
                w_state_next = (opcode == 6'h2B) ? S_MWR : S_MRD;
            end
            S_MRD: begin
                if (!mem_ready && w_wait_max) begin
                    w_timeout = 1'b1;
                    bus_err   = 1'b1;
                end else begin
                    MemRead      = 1'b1;
                    IorD         = 1'b1;
                    w_state_next = mem_ready ? S_MWB : S_MRD;
                end
            end
            S_MWB: begin
                RegWrite   = 1'b1;
                MemToReg   = 1'b1;
                instr_done = 1'b1;
            end
            S_MWR: begin
                if (!mem_ready && w_wait_max) begin
                    w_timeout = 1'b1;
                    bus_err   = 1'b1;
                end else begin
                    MemWrite     = 1'b1;
                    IorD         = 1'b1;
                    instr_done   = mem_ready;
                    w_state_next = mem_ready ? S_FETCH : S_MWR;
                end
            end
            S_R_EX: begin
                ALUSrcA      = 1'b1;
                w_state_next = S_R_WB;
                case (funct)
                    6'h20:   ALUOp = 3'b001;
                    6'h22:   ALUOp = 3'b010;
                    6'h24:   ALUOp = 3'b011;
                    6'h26:   ALUOp = 3'b110;
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        ALUOp        = 3'b000;
                        w_state_next = S_ILL;
`else
                        ALUOp        = 3'b001;
`endif
                    end
                endcase
            end
            S_R_WB: begin
                RegWrite   = 1'b1;
                RegDst     = 1'b1;
                instr_done = 1'b1;
            end
            S_I_EX: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ALUOp        = 3'b001;
                w_state_next = S_I_WB;
            end
            S_I_WB: begin
                RegWrite   = 1'b1;
                instr_done = 1'b1;
            end
            S_BR: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b010;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                instr_done  = 1'b1;
            end
            S_JMP: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                instr_done = 1'b1;
            end
`ifdef ILLEGAL_OP_TRAP_EN
            S_ILL: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b11;
                instr_done = 1'b1;
            end
`endif
            // RST and unused encodings: all outputs idle, restart at FETCH.
            default: w_state_next = S_FETCH;
        endcase
    end

endmodule

// File: tb/tb_alu_src_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_alu_src_ctrl_fsm
//   Table-driven bench for alu_src_ctrl_fsm. Each row gives the inputs for one
//   cycle and the full expected output word for that cycle. Hand-written
//   sequences cover memory timeouts, ready-on-last-count and async reset.
//   Expected word layout (23 bits):
//     {state, SrcA, SrcB[1:0], ALUOp[2:0], PCWrite, PCWriteCond, IorD,
//      MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemToReg,
//      PCSource[1:0], instr_done, bus_err}
// ---------------------------------------------------------------------------
module tb_alu_src_ctrl_fsm;

    logic       clk;
    logic       reset_n;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       mem_ready;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUOp;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegWrite, RegDst, MemToReg;
    logic [1:0] PCSource;
    logic       instr_done, bus_err;
    logic [3:0] state_dbg;

    int n_checks = 0;
    int n_fail   = 0;

    // Enable groups {PCWrite,PCWriteCond,IorD,MemRead,MemWrite,IRWrite,RegWrite,RegDst,MemToReg}
    localparam logic [8:0] F_NONE      = 9'b000000000;
    localparam logic [8:0] F_FETCH_RDY = 9'b100101000;
    localparam logic [8:0] F_FETCH     = 9'b000100000;
    localparam logic [8:0] F_MRD       = 9'b001100000;
    localparam logic [8:0] F_MWR       = 9'b001010000;
    localparam logic [8:0] F_MWB       = 9'b000000101;
    localparam logic [8:0] F_RWB       = 9'b000000110;
    localparam logic [8:0] F_IWB       = 9'b000000100;
    localparam logic [8:0] F_BR        = 9'b010000000;
    localparam logic [8:0] F_PCW       = 9'b100000000;

    typedef struct {
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        rdy;
        logic [22:0] exp;
    } vec_t;

    vec_t vecs[$];

    alu_src_ctrl_fsm #(.WAIT_MAX(15)) dut (
        .clk(clk), .reset_n(reset_n), .opcode(opcode), .funct(funct),
        .mem_ready(mem_ready), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
        .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemToReg(MemToReg), .PCSource(PCSource), .instr_done(instr_done),
        .bus_err(bus_err), .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [22:0] pack_act();
        return {state_dbg, ALUSrcA, ALUSrcB, ALUOp, PCWrite, PCWriteCond,
                IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemToReg,
                PCSource, instr_done, bus_err};
    endfunction

    function automatic vec_t mk(input logic [5:0] op, input logic [5:0] fn,
                                input logic rdy, input logic [3:0] st,
                                input logic sa, input logic [1:0] sb,
                                input logic [2:0] alu, input logic [8:0] fl,
                                input logic [1:0] pc, input logic dn,
                                input logic er);
        vec_t v;
        v.op  = op;
        v.fn  = fn;
        v.rdy = rdy;
        v.exp = {st, sa, sb, alu, fl, pc, dn, er};
        return v;
    endfunction

    // Scoreboard compare
    task automatic check(input string name, input logic [22:0] act,
                         input logic [22:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %06h expected %06h", name, act, exp);
        end
    endtask

    // Driver: apply one row, sample mid-cycle, advance to just after the edge.
    task automatic run_row(input vec_t v, input string name);
        opcode    = v.op;
        funct     = v.fn;
        mem_ready = v.rdy;
        #4;
        check(name, pack_act(), v.exp);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t fetch_rdy(input logic [5:0] op, input logic [5:0] fn);
        return mk(op, fn, 1'b1, 4'd1, 1'b0, 2'b01, 3'b001, F_FETCH_RDY, 2'b00, 1'b0, 1'b0);
    endfunction

    function automatic vec_t decode_row(input logic [5:0] op, input logic [5:0] fn);
        return mk(op, fn, 1'b0, 4'd2, 1'b0, 2'b11, 3'b001, F_NONE, 2'b00, 1'b0, 1'b0);
    endfunction

    task automatic add_fd(input logic [5:0] op, input logic [5:0] fn);
        vecs.push_back(fetch_rdy(op, fn));
        vecs.push_back(decode_row(op, fn));
    endtask

    task automatic add_rtype(input logic [5:0] fn, input logic [2:0] alu);
        add_fd(6'h00, fn);
        vecs.push_back(mk(6'h00, fn, 1'b0, 4'd7, 1'b1, 2'b00, alu, F_NONE, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(6'h00, fn, 1'b0, 4'd8, 1'b0, 2'b00, 3'b000, F_RWB, 2'b00, 1'b1, 1'b0));
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = 6'h00;
        funct     = 6'h00;
        mem_ready = 1'b0;

        // ---------------- vector table ----------------
        vecs.push_back(mk(6'h00, 6'h20, 1'b0, 4'd0, 1'b0, 2'b00, 3'b000, F_NONE, 2'b00, 1'b0, 1'b0));
        add_rtype(6'h20, 3'b001);
        add_rtype(6'h22, 3'b010);
        add_rtype(6'h24, 3'b011);
        add_rtype(6'h26, 3'b110);
        // unknown funct
        add_fd(6'h00, 6'h2A);
`ifdef ILLEGAL_OP_TRAP_EN
        vecs.push_back(mk(6'h00, 6'h2A, 1'b0, 4'd7, 1'b1, 2'b00, 3'b000, F_NONE, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(6'h00, 6'h2A, 1'b0, 4'd13, 1'b0, 2'b00, 3'b000, F_PCW, 2'b11, 1'b1, 1'b0));
`else
        vecs.push_back(mk(6'h00, 6'h2A, 1'b0, 4'd7, 1'b1, 2'b00, 3'b001, F_NONE, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(6'h00, 6'h2A, 1'b0, 4'd8, 1'b0, 2'b00, 3'b000, F_RWB, 2'b00, 1'b1, 1'b0));
`endif
        // lw: fetch waits one cycle, MRD waits 3 cycles; ready in MADDR is ignored
        vecs.push_back(mk(6'h23, 6'h00, 1'b0, 4'd1, 1'b0, 2'b01, 3'b001, F_FETCH, 2'b00, 1'b0, 1'b0));
        add_fd(6'h23, 6'h00);
        vecs.push_back(mk(6'h23, 6'h00, 1'b1, 4'd3, 1'b1, 2'b10, 3'b001, F_NONE, 2'b00, 1'b0, 1'b0));
        for (int i = 0; i < 3; i++)
            vecs.push_back(mk(6'h23, 6'h00, 1'b0, 4'd4, 1'b0, 2'b00, 3'b000, F_MRD, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(6'h23, 6'h00, 1'b1, 4'd4, 1'b0, 2'b00, 3'b000, F_MRD, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(6'h23, 6'h00, 1'b0, 4'd5, 1'b0, 2'b00, 3'b000, F_MWB, 2'b00, 1'b1, 1'b0));
        // beq
        add_fd(6'h04, 6'h00);
        vecs.push_back(mk(6'h04, 6'h00, 1'b0, 4'd11, 1'b1, 2'b00, 3'b010, F_BR, 2'b01, 1'b1, 1'b0));
        // addi
        add_fd(6'h08, 6'h00);
        vecs.push_back(mk(6'h08, 6'h00, 1'b0, 4'd9, 1'b1, 2'b10, 3'b001, F_NONE, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(6'h08, 6'h00, 1'b0, 4'd10, 1'b0, 2'b00, 3'b000, F_IWB, 2'b00, 1'b1, 1'b0));
        // j
        add_fd(6'h02, 6'h00);
        vecs.push_back(mk(6'h02, 6'h00, 1'b0, 4'd12, 1'b0, 2'b00, 3'b000, F_PCW, 2'b10, 1'b1, 1'b0));
        // sw with immediate ready
        add_fd(6'h2B, 6'h00);
        vecs.push_back(mk(6'h2B, 6'h00, 1'b0, 4'd3, 1'b1, 2'b10, 3'b001, F_NONE, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(6'h2B, 6'h00, 1'b1, 4'd6, 1'b0, 2'b00, 3'b000, F_MWR, 2'b00, 1'b1, 1'b0));
        // unknown opcode 0x3F
        vecs.push_back(fetch_rdy(6'h3F, 6'h00));
`ifdef ILLEGAL_OP_TRAP_EN
        vecs.push_back(mk(6'h3F, 6'h00, 1'b0, 4'd2, 1'b0, 2'b11, 3'b001, F_NONE, 2'b00, 1'b0, 1'b0));
        vecs.push_back(mk(6'h3F, 6'h00, 1'b0, 4'd13, 1'b0, 2'b00, 3'b000, F_PCW, 2'b11, 1'b1, 1'b0));
`else
        vecs.push_back(mk(6'h3F, 6'h00, 1'b0, 4'd2, 1'b0, 2'b11, 3'b001, F_NONE, 2'b00, 1'b1, 1'b0));
`endif

        // ---------------- reset ----------------
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold", pack_act(), 23'd0);
        reset_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_row(vecs[i], $sformatf("row%0d", i));

        // ---------------- sw timeout: 15 wait cycles, then bus_err ----------------
        run_row(fetch_rdy(6'h2B, 6'h00), "sw_fetch");
        run_row(decode_row(6'h2B, 6'h00), "sw_decode");
        run_row(mk(6'h2B, 6'h00, 1'b0, 4'd3, 1'b1, 2'b10, 3'b001, F_NONE, 2'b00, 1'b0, 1'b0), "sw_maddr");
        for (int i = 0; i < 15; i++)
            run_row(mk(6'h2B, 6'h00, 1'b0, 4'd6, 1'b0, 2'b00, 3'b000, F_MWR, 2'b00, 1'b0, 1'b0),
                    $sformatf("mwr_wait%0d", i));
        run_row(mk(6'h2B, 6'h00, 1'b0, 4'd6, 1'b0, 2'b00, 3'b000, F_NONE, 2'b00, 1'b0, 1'b1), "mwr_timeout");

        // ---------------- fetch timeout, then ready on the last count ----------------
        for (int i = 0; i < 15; i++)
            run_row(mk(6'h02, 6'h00, 1'b0, 4'd1, 1'b0, 2'b01, 3'b001, F_FETCH, 2'b00, 1'b0, 1'b0),
                    $sformatf("fetch_wait%0d", i));
        run_row(mk(6'h02, 6'h00, 1'b0, 4'd1, 1'b0, 2'b00, 3'b000, F_NONE, 2'b00, 1'b0, 1'b1), "fetch_timeout");
        for (int i = 0; i < 15; i++)
            run_row(mk(6'h02, 6'h00, 1'b0, 4'd1, 1'b0, 2'b01, 3'b001, F_FETCH, 2'b00, 1'b0, 1'b0),
                    $sformatf("fetch_rewait%0d", i));
        run_row(fetch_rdy(6'h02, 6'h00), "fetch_late_ready");
        run_row(decode_row(6'h02, 6'h00), "late_decode");
        run_row(mk(6'h02, 6'h00, 1'b0, 4'd12, 1'b0, 2'b00, 3'b000, F_PCW, 2'b10, 1'b1, 1'b0), "late_jmp");

        // ---------------- async reset in the middle of R_EX ----------------
        run_row(fetch_rdy(6'h00, 6'h20), "mid_fetch");
        run_row(decode_row(6'h00, 6'h20), "mid_decode");
        opcode    = 6'h00;
        funct     = 6'h20;
        mem_ready = 1'b0;
        #2;
        check("mid_rex", pack_act(),
              mk(6'h00, 6'h20, 1'b0, 4'd7, 1'b1, 2'b00, 3'b001, F_NONE, 2'b00, 1'b0, 1'b0).exp);
        reset_n = 1'b0;
        #1;
        check("rst_async", pack_act(), 23'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        run_row(mk(6'h00, 6'h20, 1'b0, 4'd0, 1'b0, 2'b00, 3'b000, F_NONE, 2'b00, 1'b0, 1'b0), "rst_release");
        run_row(mk(6'h00, 6'h20, 1'b0, 4'd1, 1'b0, 2'b01, 3'b001, F_FETCH, 2'b00, 1'b0, 1'b0), "fetch_after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
